enc_onehot2bin_pipe: RTL and testbench
======================================

// Module: enc_onehot2bin_pipe
// PURPOSE
//   Downstream companion of the binary-to-one-hot encoder: takes a 15-bit one-hot
//   select vector and returns its 4-bit binary index, flagging malformed vectors.
//   Two-stage registered pipeline with valid/ready handshake on both sides.
//   Sits between one-hot select producers (decoders, arbiters) and binary-indexed
//   consumers; a saturating error counter supports debug.
// PARAMETERS
//   N      15  width of one-hot input vector (legal codes 0..N-1)
//   W      4   width of binary index output, W = clog2(N)
//   CNT_W  8   width of saturating error counter
// PORTS
//   clk        input   1      rising-edge clock
//   rst        input   1      reset: one clock; asynchronous, active-high
//   in_valid   input   1      input beat valid
//   in_ready   output  1      block can accept input this cycle
//   in         input   N      one-hot select vector
//   out_valid  output  1      output beat valid
//   out_ready  input   1      downstream accepts output this cycle
//   out        output  W      binary index of lowest set bit of accepted vector
//   out_err    output  2      [0]=no bit set, [1]=more than one bit set
//   err_cnt    output  CNT_W  count of delivered beats with out_err != 0, saturating
// BEHAVIOUR
//   Reset (async assert, removal on clk edge): s1_valid=0, s2_valid=0, out=0,
//     out_err=0, out_valid=0, err_cnt=0; in_ready=1 on the first cycle after reset.
//     Reset mid-operation discards all in-flight beats; nothing is emitted for them.
//   Stage 1 (S1): registers raw vector on input handshake (in_valid & in_ready).
//   Stage 2 (S2): registers encoded out/out_err; out_valid = s2_valid.
//   Advance rules (all combinational, no bubble when flowing):
//     s2_adv   = !s2_valid | out_ready
//     in_ready = !s1_valid | s2_adv
//     S1 -> S2 transfer when s1_valid & s2_adv; S1 reloads same cycle if in handshake.
//     S2 cleared (s2_valid=0) when out_ready & !s1_valid.
//   Latency: 2 cycles from input handshake to out_valid with out_ready held high.
//   Throughput: one beat per cycle while out_ready=1.
//   Backpressure: out_ready=0 holds out/out_err/out_valid stable; S1 fills,
//     then in_ready drops to 0; no beat lost or duplicated; max 2 beats in flight.
//   in is sampled only on handshake; value when in_valid=0 is ignored.
//   Encoding: out = index of lowest set bit of vector; popcount 0 -> out=0,
//     out_err=2'b01; popcount >=2 -> out=lowest index, out_err=2'b10;
//     popcount 1 -> out_err=2'b00.
//   err_cnt: +1 on output handshake (out_valid & out_ready) with out_err != 0;
//     holds at 2**CNT_W-1 (no wrap). Never decremented except by reset.
//   out/out_err keep last value when out_valid=0 (not cleared on drain).
// TESTING
//   1. Sweep in=1<<k, k=0..14, out_ready=1 -> out=k, out_err=0, 2-cycle latency,
//      back-to-back beats, in_ready stays 1.
//   2. in=15'h0000 -> out=0, out_err=2'b01, err_cnt=1; in=15'h0050 ->
//      out=4, out_err=2'b10, err_cnt=2.
//   3. Stream 1<<3,1<<5,1<<7 with out_ready=0 -> in_ready=0 after 2 accepted;
//      release -> out=3,5,7 in order, no loss/duplication, out stable while stalled.
//   4. Random in_valid/out_ready toggling, 1000 beats -> scoreboard order and
//      values match reference model; out_valid never drops without handshake.
//   5. CNT_W=2, 5 error beats -> err_cnt sequence 1,2,3,3,3 (saturates).
//   6. Assert rst with 2 beats in flight -> out_valid=0 immediately (async),
//      err_cnt=0; neither beat emitted after release; next beat latency 2 cycles.

Source files
------------

// File: rtl/enc_onehot2bin_pipe_if.sv
// Handshake/bus bundle between a one-hot select producer, the encoder and a binary-index consumer.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; the slave modport is the encoder side.
interface enc_onehot2bin_pipe_if #(
    parameter int N = 15,
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [1:0]   out_err;

    // Producer/consumer side (drives vectors in, accepts indices out)
    modport master (
        output in_valid,
        output in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  out_err
    );

    // Encoder side
    modport slave (
        input  in_valid,
        input  in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output out_err
    );
endinterface

// File: rtl/enc_onehot2bin_pipe.sv
// One-hot to binary index encoder with malformed-vector flags and a saturating error counter.
// Latency: 2 cycles from input handshake to out_valid; one beat per cycle while out_ready=1.
// Backpressure: out_ready=0 freezes S2, S1 then fills and in_ready drops; at most 2 beats in flight.
module enc_onehot2bin_pipe #(
    parameter int N     = 15,
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    enc_onehot2bin_pipe_if.slave bus,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [N-1:0] VEC_ONE = N'(1);

    // Stage 1: raw vector
    logic             s1_valid_q, s1_valid_d;
    logic [N-1:0]     s1_vec_q,   s1_vec_d;
    // Stage 2: encoded result
    logic             s2_valid_q, s2_valid_d;
    logic [W-1:0]     s2_idx_q,   s2_idx_d;
    logic [1:0]       s2_err_q,   s2_err_d;
    // Debug counter
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             s2_adv;
    logic             in_rdy;
    logic             in_hs;
    logic             out_hs;
    logic [W-1:0]     enc_idx;
    logic [1:0]       enc_err;

    // S2 can take new data when it is empty or its beat leaves this cycle
    assign s2_adv  = !s2_valid_q || bus.out_ready;
    assign in_rdy  = !s1_valid_q || s2_adv;
    assign in_hs   = bus.in_valid && in_rdy;
    assign out_hs  = s2_valid_q && bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_valid_q;
    assign bus.out       = s2_idx_q;
    assign bus.out_err   = s2_err_q;
    assign err_cnt       = cnt_q;

    // Encode the S1 vector: lowest set bit wins; flag empty and multi-hot vectors
    always_comb begin
        enc_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (s1_vec_q[k]) begin
                enc_idx = W'(k);
            end
        end
        if (s1_vec_q == '0) begin
            enc_err = 2'b01;
        end else if ((s1_vec_q & (s1_vec_q - VEC_ONE)) != '0) begin
            // Clearing the lowest set bit leaves something: more than one bit set
            enc_err = 2'b10;
        end else begin
            enc_err = 2'b00;
        end
    end

    // Pipeline advance and saturating error count
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_vec_d   = s1_vec_q;
        s2_valid_d = s2_valid_q;
        s2_idx_d   = s2_idx_q;
        s2_err_d   = s2_err_q;
        cnt_d      = cnt_q;

        if (in_hs) begin
            s1_valid_d = 1'b1;
            s1_vec_d   = bus.in;
        end else if (s2_adv) begin
            // S1 content (if any) moved into S2 this cycle
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            // out/out_err keep their last value when S2 drains empty
            if (s1_valid_q) begin
                s2_idx_d = enc_idx;
                s2_err_d = enc_err;
            end
        end

        if (out_hs && (s2_err_q != 2'b00) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset throws away any in-flight beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_vec_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            s2_err_q   <= 2'b00;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_vec_q   <= s1_vec_d;
            s2_valid_q <= s2_valid_d;
            s2_idx_q   <= s2_idx_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_enc_onehot2bin_pipe.sv
// Directed and scoreboard checks for enc_onehot2bin_pipe (default and 2-bit counter instances).
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: out_ready driven per cycle by the stimulus.
module tb_enc_onehot2bin_pipe;
    localparam int N = 15;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    enc_onehot2bin_pipe_if #(.N(N), .W(W)) bus ();
    enc_onehot2bin_pipe_if #(.N(N), .W(W)) bus2 ();

    enc_onehot2bin_pipe #(.N(N), .W(W), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    enc_onehot2bin_pipe #(.N(N), .W(W), .CNT_W(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2),
        .err_cnt (err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus on the main instance, then settle before sampling
    task automatic step(input logic iv, input logic [N-1:0] dat, input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in        = dat;
        bus.out_ready = ordy;
        #1;
    endtask

    function automatic logic [W-1:0] ref_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return W'(k);
        end
        return '0;
    endfunction

    function automatic logic [1:0] ref_err(input logic [N-1:0] v);
        if ($countones(v) == 0) return 2'b01;
        if ($countones(v) > 1)  return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] vec;
        logic [N-1:0] one;
        logic [N-1:0] exp_q[$];
        logic [N-1:0] exp_v;
        logic         iv;
        logic         ordy;
        logic         prev_stall;
        logic [W-1:0] prev_out;
        logic [1:0]   prev_err;
        int           sent;
        int           rcvd;
        int           model_cnt;
        int           t5_exp[5];

        one = 1;
        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in         = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in        = '0;
        bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        step(1'b0, '0, 1'b1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out", bus.out, 0);
        check_eq("rst_out_err", bus.out_err, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);

        // 1: one-hot sweep, back-to-back, 2-cycle latency
        for (int c = 0; c < 17; c++) begin
            iv  = (c < 15);
            vec = (c < 15) ? (one << c) : '0;
            step(iv, vec, 1'b1);
            check_eq("t1_in_ready", bus.in_ready, 1);
            if (c >= 2) begin
                check_eq("t1_out_valid", bus.out_valid, 1);
                check_eq("t1_out", bus.out, c - 2);
                check_eq("t1_out_err", bus.out_err, 0);
            end else begin
                check_eq("t1_latency", bus.out_valid, 0);
            end
        end
        step(1'b0, '0, 1'b1);
        check_eq("t1_drained", bus.out_valid, 0);
        check_eq("t1_err_cnt", err_cnt, 0);

        // 2: empty vector then multi-hot vector
        step(1'b1, 15'h0000, 1'b1);
        step(1'b0, '0, 1'b1);
        check_eq("t2a_not_yet", bus.out_valid, 0);
        step(1'b0, '0, 1'b1);
        check_eq("t2a_valid", bus.out_valid, 1);
        check_eq("t2a_out", bus.out, 0);
        check_eq("t2a_err", bus.out_err, 2'b01);
        step(1'b0, '0, 1'b1);
        check_eq("t2a_cnt", err_cnt, 1);
        step(1'b1, 15'h0050, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check_eq("t2b_valid", bus.out_valid, 1);
        check_eq("t2b_out", bus.out, 4);
        check_eq("t2b_err", bus.out_err, 2'b10);
        step(1'b0, '0, 1'b1);
        check_eq("t2b_cnt", err_cnt, 2);

        // 3: backpressure fill, stall, release
        step(1'b1, 15'h0008, 1'b0);
        check_eq("t3_rdy0", bus.in_ready, 1);
        step(1'b1, 15'h0020, 1'b0);
        check_eq("t3_rdy1", bus.in_ready, 1);
        check_eq("t3_vld1", bus.out_valid, 0);
        step(1'b1, 15'h0080, 1'b0);
        check_eq("t3_full_rdy", bus.in_ready, 0);
        check_eq("t3_full_vld", bus.out_valid, 1);
        check_eq("t3_full_out", bus.out, 3);
        step(1'b1, 15'h0080, 1'b0);
        check_eq("t3_stall_rdy", bus.in_ready, 0);
        check_eq("t3_stall_vld", bus.out_valid, 1);
        check_eq("t3_stall_out", bus.out, 3);
        step(1'b1, 15'h0080, 1'b1);
        check_eq("t3_rel_rdy", bus.in_ready, 1);
        check_eq("t3_rel_out", bus.out, 3);
        step(1'b0, '0, 1'b1);
        check_eq("t3_out5_vld", bus.out_valid, 1);
        check_eq("t3_out5", bus.out, 5);
        step(1'b0, '0, 1'b1);
        check_eq("t3_out7_vld", bus.out_valid, 1);
        check_eq("t3_out7", bus.out, 7);
        step(1'b0, '0, 1'b1);
        check_eq("t3_empty", bus.out_valid, 0);
        check_eq("t3_hold_out", bus.out, 7);
        check_eq("t3_cnt", err_cnt, 2);

        // 4: random handshakes against a scoreboard
        sent = 0;
        rcvd = 0;
        model_cnt = 2;
        prev_stall = 1'b0;
        prev_out = '0;
        prev_err = '0;
        for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
            iv   = (sent < 1000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       vec = '0;
                1:       vec = N'($urandom);
                default: vec = one << $urandom_range(0, N - 1);
            endcase
            step(iv, vec, ordy);
            if (prev_stall) begin
                check_eq("t4_hold_vld", bus.out_valid, 1);
                check_eq("t4_hold_out", {bus.out_err, bus.out}, {prev_err, prev_out});
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq("t4_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check_eq("t4_out", bus.out, ref_idx(exp_v));
                    check_eq("t4_err", bus.out_err, ref_err(exp_v));
                    if (ref_err(exp_v) != 2'b00 && model_cnt < 255) model_cnt++;
                end
                rcvd++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = bus.out;
            prev_err   = bus.out_err;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(vec);
                sent++;
            end
        end
        check_eq("t4_beats", rcvd, 1000);
        step(1'b0, '0, 1'b1);
        check_eq("t4_cnt", err_cnt, model_cnt);

        // 5: 2-bit counter saturates at 3
        t5_exp = '{1, 2, 3, 3, 3};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus2.in_valid  = (c < 5);
            bus2.in        = (c % 2 == 0) ? 15'h0000 : 15'h0050;
            bus2.out_ready = 1'b1;
            #1;
            if (c >= 3) check_eq("t5_cnt", err_cnt2, t5_exp[c - 3]);
            else        check_eq("t5_cnt_pre", err_cnt2, 0);
        end

        // 6: reset with two beats in flight
        step(1'b1, 15'h0004, 1'b0);
        step(1'b1, 15'h0010, 1'b0);
        step(1'b0, '0, 1'b0);
        check_eq("t6_pre_vld", bus.out_valid, 1);
        check_eq("t6_pre_out", bus.out, 2);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t6_async_vld", bus.out_valid, 0);
        check_eq("t6_async_cnt", err_cnt, 0);
        check_eq("t6_async_out", bus.out, 0);
        check_eq("t6_async_cnt2", err_cnt2, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, '0, 1'b1);
            check_eq("t6_no_ghost", bus.out_valid, 0);
        end
        step(1'b1, 15'h0200, 1'b1);
        check_eq("t6_rdy", bus.in_ready, 1);
        step(1'b0, '0, 1'b1);
        check_eq("t6_lat1", bus.out_valid, 0);
        step(1'b0, '0, 1'b1);
        check_eq("t6_lat2_vld", bus.out_valid, 1);
        check_eq("t6_lat2_out", bus.out, 9);
        check_eq("t6_lat2_err", bus.out_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
